cphy_rx_symbol_decoder: RTL and testbench

Downstream of the slave analog front end. Consumes the three HS comparator outputs (A=A>B, B=B>C, C=C>A) sampled once per UI on clk. Converts successive wire states into 3-bit C-PHY symbols, hunts for the preamble and sync word, then packs data symbols into 7-symbol (21-bit) groups for the 7-to-16 demapper.

---
 rtl/cphy_pkg.sv | 28 ++
 rtl/cphy_symbol_lut.sv | 18 +
 rtl/cphy_rx_symbol_decoder.sv | 121 ++++++++++++
 tb/tb_cphy_rx_symbol_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cphy_pkg.sv
// cphy_pkg: shared wire-state codes, symbol values, FSM states and sync word for the C-PHY receive path
package cphy_pkg;
  localparam logic [2:0] WS_PX = 3'b100;
  localparam logic [2:0] WS_NX = 3'b011;
  localparam logic [2:0] WS_PY = 3'b010;
  localparam logic [2:0] WS_NY = 3'b101;
  localparam logic [2:0] WS_PZ = 3'b001;
  localparam logic [2:0] WS_NZ = 3'b110;
  localparam logic [2:0] SYM_0 = 3'd0;
  localparam logic [2:0] SYM_1 = 3'd1;
  localparam logic [2:0] SYM_2 = 3'd2;
  localparam logic [2:0] SYM_3 = 3'd3;
  localparam logic [2:0] SYM_4 = 3'd4;
  localparam logic [20:0] SYNC_PAT = 21'o3444443;
  typedef enum logic [2:0] {IDLE, FIRST, HUNT, SYNC, DATA} state_e;
  function automatic logic ws_valid(input logic [2:0] ws);
    return ws inside {WS_PX, WS_NX, WS_PY, WS_NY, WS_PZ, WS_NZ};
  endfunction
  function automatic logic ws_pos(input logic [2:0] ws);
    return ws inside {WS_PX, WS_PY, WS_PZ};
  endfunction
  // x=0, y=1, z=2; negative states are the bitwise complement of their positive partner
  function automatic logic [1:0] ws_pair(input logic [2:0] ws);
    logic [2:0] oh;
    oh = ws_pos(ws) ? ws : ~ws;
    return oh[2] ? 2'd0 : oh[1] ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/cphy_symbol_lut.sv
// cphy_symbol_lut: maps a previous/current wire-state pair to a 3-bit C-PHY symbol
module cphy_symbol_lut
  import cphy_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] cur,
  output logic [2:0] sym,
  output logic       sym_ok
);
  logic [1:0] pp, cp;
  logic cw, pol_chg;
  assign pp = ws_pair(prev);
  assign cp = ws_pair(cur);
  assign cw = cp == ((pp == 2'd2) ? 2'd0 : pp + 2'd1);
  assign pol_chg = ws_pos(prev) != ws_pos(cur);
  assign sym_ok = ws_valid(prev) && ws_valid(cur) && prev != cur;
  assign sym = (pp == cp) ? SYM_4 : {1'b0, cw, pol_chg};
endmodule

// File: rtl/cphy_rx_symbol_decoder.sv
// cphy_rx_symbol_decoder: turns sampled C-PHY wire states into symbols, locks on preamble/sync, packs 7-symbol groups
module cphy_rx_symbol_decoder
  import cphy_pkg::*;
#(
  parameter int N_PRE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HsRxEn,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  output logic [20:0] sym_data,
  output logic        sym_valid,
  output logic        sync_det,
  output logic        sym_err
);
  state_e state_q, state_d;
  logic [2:0] prev_q, prev_d, sync_cnt_q, sync_cnt_d, slot_q, slot_d, sym, sync_exp;
  logic [3:0] pre_cnt_q, pre_cnt_d;
  logic [17:0] grp_q, grp_d;
  logic [20:0] sym_data_q, sym_data_d;
  logic sym_valid_q, sym_valid_d, sync_det_q, sync_det_d, sym_err_q, sym_err_d, sym_ok;
  logic [2:0] cur;
  logic [4:0] sync_base;
  assign cur = {A, B, C};
  cphy_symbol_lut u_lut (.prev(prev_q), .cur(cur), .sym(sym), .sym_ok(sym_ok));
  // sync_cnt_q is the index of the last matched sync-word symbol; compare against the next one
  assign sync_base = 5'd15 - 5'd3 * {2'b0, sync_cnt_q};
  assign sync_exp = SYNC_PAT[sync_base +: 3];
  always_comb begin
    state_d = state_q;
    prev_d = prev_q;
    pre_cnt_d = pre_cnt_q;
    sync_cnt_d = sync_cnt_q;
    slot_d = slot_q;
    grp_d = grp_q;
    sym_data_d = sym_data_q;
    sym_valid_d = 1'b0;
    sym_err_d = 1'b0;
    if (!HsRxEn) begin
      state_d = IDLE;
      prev_d = '0;
      pre_cnt_d = '0;
      sync_cnt_d = '0;
      slot_d = '0;
    end else if (state_q == IDLE) begin
      state_d = FIRST;
    end else if (state_q == FIRST) begin
      if (ws_valid(cur)) begin
        state_d = HUNT;
        prev_d = cur;
        pre_cnt_d = '0;
      end
    end else if (!sym_ok) begin
      sym_err_d = 1'b1;
      state_d = FIRST;
      prev_d = '0;
      pre_cnt_d = '0;
      sync_cnt_d = '0;
      slot_d = '0;
    end else begin
      prev_d = cur;
      case (state_q)
        HUNT: begin
          pre_cnt_d = (sym != SYM_3) ? '0 : (pre_cnt_q == 4'd15) ? pre_cnt_q : pre_cnt_q + 4'd1;
          if (sym == SYM_4 && pre_cnt_q >= 4'(N_PRE)) begin
            state_d = SYNC;
            sync_cnt_d = 3'd1;
          end
        end
        SYNC: begin
          if (sym != sync_exp) begin
            state_d = HUNT;
            pre_cnt_d = {3'b0, sym == SYM_3};
          end else if (sync_cnt_q == 3'd5) begin
            state_d = DATA;
          end else begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end
        end
        default: begin
          grp_d = {grp_q[14:0], sym};
          slot_d = (slot_q == 3'd6) ? '0 : slot_q + 3'd1;
          sym_data_d = (slot_q == 3'd6) ? {grp_q, sym} : sym_data_q;
          sym_valid_d = slot_q == 3'd6;
        end
      endcase
    end
    sync_det_d = state_d == DATA;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q <= '0;
      pre_cnt_q <= '0;
      sync_cnt_q <= '0;
      slot_q <= '0;
      grp_q <= '0;
      sym_data_q <= '0;
      sym_valid_q <= 1'b0;
      sync_det_q <= 1'b0;
      sym_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      pre_cnt_q <= pre_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      slot_q <= slot_d;
      grp_q <= grp_d;
      sym_data_q <= sym_data_d;
      sym_valid_q <= sym_valid_d;
      sync_det_q <= sync_det_d;
      sym_err_q <= sym_err_d;
    end
  end
  assign sym_data = sym_data_q;
  assign sym_valid = sym_valid_q;
  assign sync_det = sync_det_q;
  assign sym_err = sym_err_q;
endmodule

// File: tb/tb_cphy_rx_symbol_decoder.sv
// tb_cphy_rx_symbol_decoder: LUT vector table plus scoreboarded lock/group/error/enable/reset sequences
module tb_cphy_rx_symbol_decoder;
  logic clk = 1'b0, rst = 1'b1, HsRxEn = 1'b0, A = 1'b0, B = 1'b0, C = 1'b0;
  logic [20:0] sym_data;
  logic sym_valid, sync_det, sym_err;
  logic [2:0] lut_prev, lut_cur, lut_sym;
  logic lut_ok;
  int tests = 0, fails = 0, err_seen = 0, valid_seen = 0;
  logic [20:0] exp_q[$];
  logic [20:0] exp_mon, last_grp = '0;
  logic [2:0] cur_ws = 3'b100;
  typedef struct {
    logic [2:0] prev;
    logic [2:0] cur;
    logic [2:0] sym;
    logic       ok;
  } lut_vec_t;
  lut_vec_t vecs[$];

  always #5 clk = ~clk;

  cphy_rx_symbol_decoder #(.N_PRE(7)) dut (
    .clk(clk), .rst(rst), .HsRxEn(HsRxEn), .A(A), .B(B), .C(C),
    .sym_data(sym_data), .sym_valid(sym_valid), .sync_det(sync_det), .sym_err(sym_err)
  );
  cphy_symbol_lut u_lut (.prev(lut_prev), .cur(lut_cur), .sym(lut_sym), .sym_ok(lut_ok));

  function automatic logic [2:0] code(input int pair, input bit neg);
    logic [2:0] p;
    p = 3'b100 >> pair;
    return neg ? ~p : p;
  endfunction

  // returns {ok, symbol} from the rotation/polarity rules
  function automatic logic [3:0] model(input logic [2:0] p, input logic [2:0] c);
    int pp = -1, cp = -1;
    bit pn = 0, cn = 0;
    for (int i = 0; i < 3; i++)
      for (int n = 0; n < 2; n++) begin
        if (code(i, n[0]) == p) begin pp = i; pn = n[0]; end
        if (code(i, n[0]) == c) begin cp = i; cn = n[0]; end
      end
    if (pp < 0 || cp < 0 || p == c) return 4'b0000;
    if (pp == cp) return 4'b1100;
    return {2'b10, 1'(cp == (pp + 1) % 3), 1'(pn != cn)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] ws);
    {A, B, C} = ws;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    logic [2:0] w, nxt;
    bit found = 0;
    nxt = cur_ws;
    for (int i = 0; i < 3; i++)
      for (int n = 0; n < 2; n++) begin
        w = code(i, n[0]);
        if (!found && model(cur_ws, w) == {1'b1, 3'(s)}) begin nxt = w; found = 1; end
      end
    cur_ws = nxt;
    step(nxt);
  endtask

  task automatic enter();
    HsRxEn = 1'b0;
    step(3'b100);
    HsRxEn = 1'b1;
    step(3'b100);
    step(3'b100);
    cur_ws = 3'b100;
  endtask

  task automatic lock(input int n);
    enter();
    repeat (n) send(3);
    repeat (5) send(4);
    chk("sync_det_before_final3", 32'(sync_det), 0);
    send(3);
  endtask

  task automatic group(input logic [20:0] g);
    exp_q.push_back(g);
    for (int k = 0; k < 7; k++) begin
      send(int'(g[18 - 3 * k +: 3]));
      if (k == 0) chk("sym_data_hold", 32'(sym_data), 32'(last_grp));
      if (k < 6) chk("no_early_valid", 32'(sym_valid), 0);
    end
    chk("valid_strobe", 32'(sym_valid), 1);
    last_grp = g;
  endtask

  always @(negedge clk) begin
    if (sym_err) err_seen++;
    if (sym_valid) begin
      valid_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got sym_data %o, expected no strobe", sym_data);
      end else begin
        exp_mon = exp_q.pop_front();
        if (sym_data !== exp_mon) begin
          fails++;
          $display("FAIL group_data: got %o, expected %o", sym_data, exp_mon);
        end
      end
    end
  end

  initial begin
    int v0, e0;
    vecs.push_back('{3'b100, 3'b010, 3'd2, 1'b1});
    vecs.push_back('{3'b100, 3'b011, 3'd4, 1'b1});
    vecs.push_back('{3'b100, 3'b101, 3'd3, 1'b1});
    vecs.push_back('{3'b100, 3'b001, 3'd0, 1'b1});
    vecs.push_back('{3'b100, 3'b110, 3'd1, 1'b1});
    vecs.push_back('{3'b010, 3'b010, 3'd0, 1'b0});
    vecs.push_back('{3'b000, 3'b100, 3'd0, 1'b0});
    vecs.push_back('{3'b100, 3'b111, 3'd0, 1'b0});
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 8; c++) begin
        logic [3:0] m;
        m = model(3'(p), 3'(c));
        vecs.push_back('{3'(p), 3'(c), m[2:0], m[3]});
      end
    foreach (vecs[i]) begin
      lut_prev = vecs[i].prev;
      lut_cur = vecs[i].cur;
      #1;
      chk($sformatf("lut_ok_%b_%b", lut_prev, lut_cur), 32'(lut_ok), 32'(vecs[i].ok));
      if (vecs[i].ok) chk($sformatf("lut_sym_%b_%b", lut_prev, lut_cur), 32'(lut_sym), 32'(vecs[i].sym));
    end
    // reset holds everything at zero even with HsRxEn high
    rst = 1'b1;
    HsRxEn = 1'b1;
    step(3'b100);
    step(3'b010);
    chk("rst_sym_data", 32'(sym_data), 0);
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_sync_det", 32'(sync_det), 0);
    chk("rst_sym_err", 32'(sym_err), 0);
    rst = 1'b0;
    // nominal lock then two back-to-back groups
    lock(8);
    chk("lock_sync_det", 32'(sync_det), 1);
    group(21'o0123401);
    group(21'o4321012);
    // short preamble must not lock
    lock(5);
    chk("short_pre_sync_det", 32'(sync_det), 0);
    v0 = valid_seen;
    for (int k = 0; k < 10; k++) send(k % 3);
    chk("short_pre_no_valid", 32'(valid_seen), 32'(v0));
    chk("short_pre_sync_det_after", 32'(sync_det), 0);
    // line errors in DATA: invalid code, then repeated state
    lock(7);
    chk("boundary_lock_sync_det", 32'(sync_det), 1);
    e0 = err_seen;
    v0 = valid_seen;
    send(0); send(1); send(2);
    step(3'b111);
    chk("invalid_sym_err", 32'(sym_err), 1);
    chk("invalid_sync_det", 32'(sync_det), 0);
    step(3'b010);
    chk("invalid_err_one_cycle", 32'(sym_err), 0);
    lock(7);
    send(1); send(2);
    step(cur_ws);
    chk("repeat_sym_err", 32'(sym_err), 1);
    chk("repeat_sync_det", 32'(sync_det), 0);
    step(cur_ws);
    chk("repeat_err_one_cycle", 32'(sym_err), 0);
    chk("err_count", 32'(err_seen), 32'(e0 + 2));
    chk("err_no_valid", 32'(valid_seen), 32'(v0));
    // HsRxEn drop mid-group
    lock(7);
    e0 = err_seen;
    send(4); send(4); send(0); send(3);
    HsRxEn = 1'b0;
    step(cur_ws);
    chk("drop_sync_det", 32'(sync_det), 0);
    chk("drop_sym_err", 32'(sym_err), 0);
    step(3'b111);
    step(3'b000);
    step(3'b010);
    chk("drop_no_valid", 32'(valid_seen), 32'(v0));
    chk("drop_no_err", 32'(err_seen), 32'(e0));
    lock(8);
    group(21'o4403210);
    // reset during DATA
    lock(7);
    send(2); send(1); send(0);
    rst = 1'b1;
    step(cur_ws);
    chk("midrst_sym_data", 32'(sym_data), 0);
    chk("midrst_sym_valid", 32'(sym_valid), 0);
    chk("midrst_sync_det", 32'(sync_det), 0);
    chk("midrst_sym_err", 32'(sym_err), 0);
    HsRxEn = 1'b1;
    step(3'b100); step(3'b101); step(3'b111);
    chk("rst_hold_sync_det", 32'(sync_det), 0);
    chk("rst_hold_sym_err", 32'(sym_err), 0);
    rst = 1'b0;
    last_grp = '0;
    lock(7);
    chk("relock_sync_det", 32'(sync_det), 1);
    group(21'o2104321);
    step(cur_ws);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
